// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register. It adds memory lane preparation, validity and HALT tracking.
// Optional retired-instruction counter: define EX_MEM_RETIRE_CNT_EN.
module ex_mem_stage_reg #(
   parameter int DATA_BUS_WIDTH = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_enable,
   input  logic                      i_flush,
   input  logic                      i_valid,
   input  logic [DATA_BUS_WIDTH-1:0] i_alu_result,
   input  logic [DATA_BUS_WIDTH-1:0] i_store_data,
   input  logic [REG_ADDR_WIDTH-1:0] i_wb_addr,
   input  logic                      i_reg_wr,
   input  logic                      i_mem_rd,
   input  logic                      i_mem_wr,
   input  logic                      i_mem_to_reg,
   input  logic                      i_mem_unsigned,
   input  logic [1:0]                i_mem_size,
   input  logic                      i_halt,
   output logic [DATA_BUS_WIDTH-1:0] o_alu_result,
   output logic [DATA_BUS_WIDTH-1:0] o_store_data,
   output logic [REG_ADDR_WIDTH-1:0] o_wb_addr,
   output logic                      o_reg_wr,
   output logic                      o_mem_rd,
   output logic                      o_mem_wr,
   output logic                      o_mem_to_reg,
   output logic                      o_mem_unsigned,
   output logic [1:0]                o_mem_size,
   output logic [3:0]                o_byte_en,
   output logic                      o_misaligned,
   output logic                      o_valid,
   output logic                      o_halted,
   output logic [CNT_WIDTH-1:0]      o_retired_count
);

   logic [1:0]                w_addr_lo;
   logic                      w_mem_access;
   logic                      w_mis_raw;
   logic                      w_misaligned;
   logic [3:0]                w_be_raw;
   logic [3:0]                w_byte_en;
   logic [DATA_BUS_WIDTH-1:0] w_store_data;
   logic                      w_bubble;
   logic                      w_load;

   logic [DATA_BUS_WIDTH-1:0] r_alu_result;
   logic [DATA_BUS_WIDTH-1:0] r_store_data;
   logic [REG_ADDR_WIDTH-1:0] r_wb_addr;
   logic                      r_reg_wr;
   logic                      r_mem_rd;
   logic                      r_mem_wr;
   logic                      r_mem_to_reg;
   logic                      r_mem_unsigned;
   logic [1:0]                r_mem_size;
   logic [3:0]                r_byte_en;
   logic                      r_misaligned;
   logic                      r_valid;
   logic                      r_halted;

   assign w_addr_lo    = i_alu_result[1:0];
   assign w_mem_access = i_mem_rd | i_mem_wr;

   always_comb begin
      w_be_raw     = 4'b1111;
      w_mis_raw    = 1'b0;
      w_store_data = i_store_data;
      unique case (i_mem_size)
         2'b00: begin
            w_be_raw     = 4'b0001 << w_addr_lo;
            w_store_data = {(DATA_BUS_WIDTH/8){i_store_data[7:0]}};
         end
         2'b01: begin
            w_be_raw     = 4'b0011 << w_addr_lo;
            w_mis_raw    = w_addr_lo[0];
            w_store_data = {(DATA_BUS_WIDTH/16){i_store_data[15:0]}};
         end
         default: begin
            w_be_raw  = 4'b1111;
            w_mis_raw = (w_addr_lo != 2'b00);
         end
      endcase
   end

   assign w_misaligned = w_mem_access & w_mis_raw;
   assign w_byte_en    = (w_mem_access && !w_misaligned) ? w_be_raw : 4'b0000;

   // A frozen (halted) stage ignores both flush and enable.
   assign w_bubble = !r_halted && (i_flush || (i_enable && !i_valid));
   assign w_load   = !r_halted && !i_flush && i_enable && i_valid;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_alu_result   <= '0;
         r_store_data   <= '0;
         r_wb_addr      <= '0;
         r_reg_wr       <= 1'b0;
         r_mem_rd       <= 1'b0;
         r_mem_wr       <= 1'b0;
         r_mem_to_reg   <= 1'b0;
         r_mem_unsigned <= 1'b0;
         r_mem_size     <= 2'b00;
         r_byte_en      <= 4'b0000;
         r_misaligned   <= 1'b0;
         r_valid        <= 1'b0;
         r_halted       <= 1'b0;
      end else if (w_bubble) begin
         r_alu_result   <= '0;
         r_store_data   <= '0;
         r_wb_addr      <= '0;
         r_reg_wr       <= 1'b0;
         r_mem_rd       <= 1'b0;
         r_mem_wr       <= 1'b0;
         r_mem_to_reg   <= 1'b0;
         r_mem_unsigned <= 1'b0;
         r_mem_size     <= 2'b00;
         r_byte_en      <= 4'b0000;
         r_misaligned   <= 1'b0;
         r_valid        <= 1'b0;
      end else if (w_load) begin
         r_alu_result   <= i_alu_result;
         r_store_data   <= w_store_data;
         r_wb_addr      <= i_wb_addr;
         r_reg_wr       <= i_reg_wr && (i_wb_addr != '0) && !w_misaligned;
         r_mem_rd       <= i_mem_rd && !w_misaligned;
         r_mem_wr       <= i_mem_wr && !w_misaligned;
         r_mem_to_reg   <= i_mem_to_reg;
         r_mem_unsigned <= i_mem_unsigned;
         r_mem_size     <= i_mem_size;
         r_byte_en      <= w_byte_en;
         r_misaligned   <= w_misaligned;
         r_valid        <= 1'b1;
         r_halted       <= i_halt;
      end
   end

`ifdef EX_MEM_RETIRE_CNT_EN
   logic [CNT_WIDTH-1:0] r_retired_count;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_retired_count <= '0;
      end else if (w_load) begin
         r_retired_count <= r_retired_count + 1'b1;
      end
   end

   assign o_retired_count = r_retired_count;
`else
   assign o_retired_count = '0;
`endif

   assign o_alu_result   = r_alu_result;
   assign o_store_data   = r_store_data;
   assign o_wb_addr      = r_wb_addr;
   assign o_reg_wr       = r_reg_wr;
   assign o_mem_rd       = r_mem_rd;
   assign o_mem_wr       = r_mem_wr;
   assign o_mem_to_reg   = r_mem_to_reg;
   assign o_mem_unsigned = r_mem_unsigned;
   assign o_mem_size     = r_mem_size;
   assign o_byte_en      = r_byte_en;
   assign o_misaligned   = r_misaligned;
   assign o_valid        = r_valid;
   assign o_halted       = r_halted;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Scoreboard bench for ex_mem_stage_reg; counter width 4 so wrap is reachable.
module tb_ex_mem_stage_reg;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] sd;
      logic [4:0]  wb;
      logic        reg_wr;
      logic        rd;
      logic        wr;
      logic        m2r;
      logic        uns;
      logic [1:0]  size;
      logic [3:0]  be;
      logic        mis;
      logic        valid;
      logic        halted;
      logic [3:0]  cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en, fl, vld, reg_wr, mem_rd, mem_wr, m2r, uns, halt;
   logic [31:0] alu, sdat;
   logic [4:0]  wb;
   logic [1:0]  size;

   logic [31:0] o_alu, o_sd;
   logic [4:0]  o_wb;
   logic        o_reg_wr, o_rd, o_wr, o_m2r, o_uns, o_mis, o_valid, o_halted;
   logic [1:0]  o_size;
   logic [3:0]  o_be, o_cnt;

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t model;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   ex_mem_stage_reg #(.DATA_BUS_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) dut (
      .i_clk(clk), .i_reset(rst), .i_enable(en), .i_flush(fl), .i_valid(vld),
      .i_alu_result(alu), .i_store_data(sdat), .i_wb_addr(wb),
      .i_reg_wr(reg_wr), .i_mem_rd(mem_rd), .i_mem_wr(mem_wr),
      .i_mem_to_reg(m2r), .i_mem_unsigned(uns), .i_mem_size(size), .i_halt(halt),
      .o_alu_result(o_alu), .o_store_data(o_sd), .o_wb_addr(o_wb),
      .o_reg_wr(o_reg_wr), .o_mem_rd(o_rd), .o_mem_wr(o_wr),
      .o_mem_to_reg(o_m2r), .o_mem_unsigned(o_uns), .o_mem_size(o_size),
      .o_byte_en(o_be), .o_misaligned(o_mis), .o_valid(o_valid),
      .o_halted(o_halted), .o_retired_count(o_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Reference behaviour of one clock edge, from the current inputs.
   function automatic exp_t model_next(exp_t cur);
      exp_t       n = cur;
      logic [1:0] a = alu[1:0];
      logic       acc = mem_rd | mem_wr;
      logic       bad;
      if (cur.halted) return cur;
      if (fl || (en && !vld)) begin
         n = '0;
         n.cnt = cur.cnt;
         return n;
      end
      if (!en) return cur;
      case (size)
         2'b00: begin bad = 1'b0; n.be = 4'b0001 << a; n.sd = {4{sdat[7:0]}}; end
         2'b01: begin bad = a[0]; n.be = 4'b0011 << a; n.sd = {2{sdat[15:0]}}; end
         default: begin bad = (a != 2'b00); n.be = 4'b1111; n.sd = sdat; end
      endcase
      n.mis    = acc && bad;
      if (!acc || n.mis) n.be = 4'b0000;
      n.alu    = alu;
      n.wb     = wb;
      n.reg_wr = reg_wr && (wb != 5'd0) && !n.mis;
      n.rd     = mem_rd && !n.mis;
      n.wr     = mem_wr && !n.mis;
      n.m2r    = m2r;
      n.uns    = uns;
      n.size   = size;
      n.valid  = 1'b1;
      n.halted = halt;
`ifdef EX_MEM_RETIRE_CNT_EN
      n.cnt    = cur.cnt + 4'd1;
`endif
      return n;
   endfunction

   task automatic compare(input string tag, input exp_t e);
      chk({tag, ".alu"},    64'(o_alu),    64'(e.alu));
      chk({tag, ".sd"},     64'(o_sd),     64'(e.sd));
      chk({tag, ".wb"},     64'(o_wb),     64'(e.wb));
      chk({tag, ".reg_wr"}, 64'(o_reg_wr), 64'(e.reg_wr));
      chk({tag, ".rd"},     64'(o_rd),     64'(e.rd));
      chk({tag, ".wr"},     64'(o_wr),     64'(e.wr));
      chk({tag, ".be"},     64'(o_be),     64'(e.be));
      chk({tag, ".mis"},    64'(o_mis),    64'(e.mis));
      chk({tag, ".valid"},  64'(o_valid),  64'(e.valid));
      chk({tag, ".halted"}, 64'(o_halted), 64'(e.halted));
      chk({tag, ".cnt"},    64'(o_cnt),    64'(e.cnt));
      if (e.valid) begin
         chk({tag, ".m2r"},  64'(o_m2r),  64'(e.m2r));
         chk({tag, ".uns"},  64'(o_uns),  64'(e.uns));
         chk({tag, ".size"}, 64'(o_size), 64'(e.size));
      end
   endtask

   task automatic cycle(input string tag);
      exp_t e;
      model = model_next(model);
      sb_q.push_back(model);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         chk({tag, ".sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb_q.pop_front();
         compare(tag, e);
      end
   endtask

   task automatic ld(input logic [31:0] a, input logic [31:0] d, input logic [4:0] w,
                     input logic rw, input logic r, input logic wr_, input logic [1:0] s,
                     input logic h);
      en = 1'b1; fl = 1'b0; vld = 1'b1;
      alu = a; sdat = d; wb = w; reg_wr = rw; mem_rd = r; mem_wr = wr_;
      m2r = r; uns = 1'b0; size = s; halt = h;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #2;
      sb_q.delete();
      model = '0;
      compare(tag, model);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      en = $urandom; fl = $urandom; vld = $urandom; halt = 1'b0;
      alu = $urandom; sdat = $urandom; wb = 5'($urandom);
      reg_wr = $urandom; mem_rd = $urandom; mem_wr = $urandom;
      m2r = $urandom; uns = $urandom; size = 2'($urandom);
      #3;
      do_reset("reset");

      ld(32'h10, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
      cycle("add");
      chk("add.alu_const", 64'(o_alu), 64'h10);
      chk("add.wb_const", 64'(o_wb), 64'd3);

      ld(32'h6, 32'h1234_56AB, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
      cycle("sb");
      chk("sb.be_const", 64'(o_be), 64'b0100);
      chk("sb.sd_const", 64'(o_sd), 64'hABAB_ABAB);

      ld(32'h6, 32'h1234_56AB, 5'd0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
      cycle("sw_mis");
      chk("sw_mis.mis_const", 64'(o_mis), 64'd1);
      chk("sw_mis.valid_const", 64'(o_valid), 64'd1);

      ld(32'h2, 32'hBEEF_CAFE, 5'd7, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
      cycle("lh_ok");
      ld(32'h1, 32'hBEEF_CAFE, 5'd7, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
      cycle("lh_mis");
      ld(32'h7, 32'h5555_AAAA, 5'd9, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0);
      cycle("alu_nomem");

      ld(32'h100, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
      cycle("lw");
      en = 1'b0;
      alu = 32'hFFFF_FFFF; vld = 1'b1;
      for (int i = 0; i < 3; i++) cycle("stall");
      chk("stall.alu_const", 64'(o_alu), 64'h100);
      fl = 1'b1;
      cycle("flush_stall");

      ld(32'h20, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
      cycle("zero_reg");
      chk("zero_reg.const", 64'(o_reg_wr), 64'd0);

      ld(32'h44, 32'h1, 5'd4, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
      vld = 1'b0;
      cycle("invalid_load");

      for (int i = 0; i < 12; i++) begin
         ld($urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            2'($urandom), 1'b0);
         vld = 1'($urandom);
         en  = ($urandom_range(0, 3) != 0);
         fl  = ($urandom_range(0, 5) == 0);
         cycle("rand");
      end

      do_reset("reset2");
      for (int i = 0; i < 17; i++) begin
         ld($urandom, $urandom, 5'd1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
         cycle("wrap");
      end
`ifdef EX_MEM_RETIRE_CNT_EN
      chk("wrap.cnt_const", 64'(o_cnt), 64'd1);
`else
      chk("wrap.cnt_tied", 64'(o_cnt), 64'd0);
`endif

      do_reset("reset3");
      for (int i = 0; i < 3; i++) begin
         ld(32'h40 + 32'(i * 4), 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
         cycle("pre_halt");
      end
      ld(32'hDEAD_0000, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1);
      cycle("halt");
      for (int i = 0; i < 3; i++) begin
         ld(32'h9000 + 32'(i), 32'h77, 5'd5, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
         cycle("frozen");
      end
      fl = 1'b1;
      cycle("frozen_flush");
      chk("halt.halted_const", 64'(o_halted), 64'd1);
      chk("halt.alu_const", 64'(o_alu), 64'hDEAD_0000);
`ifdef EX_MEM_RETIRE_CNT_EN
      chk("halt.cnt_const", 64'(o_cnt), 64'd4);
`endif
      fl = 1'b0;
      do_reset("reset_frozen");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
